// File: rtl/pifo_rank_queue_if.sv
// pifo_rank_queue_if: enqueue/dequeue handshake bundle for pifo_rank_queue.
//   enq_valid/enq_data/enq_ready : rank tuple input from the WRR rank calculator
//   deq_req/deq_valid/deq_data   : scheduler pop request and popped tuple
// master = tuple producer / scheduler side, slave = the queue.
interface pifo_rank_queue_if;
  logic        enq_valid;
  logic [31:0] enq_data;
  logic        enq_ready;
  logic        deq_req;
  logic        deq_valid;
  logic [31:0] deq_data;

  modport master (
    output enq_valid, enq_data, deq_req,
    input  enq_ready, deq_valid, deq_data
  );

  modport slave (
    input  enq_valid, enq_data, deq_req,
    output enq_ready, deq_valid, deq_data
  );
endinterface

// File: rtl/pifo_rank_queue.sv
// pifo_rank_queue: shift-register PIFO ordering WRR rank tuples, smallest rank first.
//   clk_dp, rst_n        : data-plane clock, async active-low reset
//   bus (slave)          : enq_valid/enq_data/enq_ready, deq_req/deq_valid/deq_data
//   last_pkt_info0..4    : last tuple popped per port, fed back to the rank calculator
//   count                : occupancy
//   drop_cnt             : saturating count of rejected enqueues
//   cur_epoch            : ovf field of the most recent pop
// Tuple: {v[31], unused[30], class[29:25], ovf[24:23], round[22:12], rsvd[11:3], port[2:0]}
module pifo_rank_queue #(
  parameter int DEPTH     = 16,
  parameter int NUM_PORTS = 5
) (
  input  logic               clk_dp,
  input  logic               rst_n,
  pifo_rank_queue_if.slave   bus,
  output logic [31:0]        last_pkt_info0,
  output logic [31:0]        last_pkt_info1,
  output logic [31:0]        last_pkt_info2,
  output logic [31:0]        last_pkt_info3,
  output logic [31:0]        last_pkt_info4,
  output logic [6:0]         count,
  output logic [15:0]        drop_cnt,
  output logic [1:0]         cur_epoch
);
  localparam int KW = 13;

  // Key is rebased on cur_epoch every cycle: the ovf distance ahead of the
  // current epoch, then round. Class and the unused bit are ignored.
  function automatic logic [KW-1:0] key_of(input logic [31:0] d, input logic [1:0] ep);
    logic [1:0] rel;
    rel = d[24:23] - ep;
    return {rel, d[22:12]};
  endfunction

  logic [DEPTH-1:0][31:0]     slot_q, slot_d, slot_up, slot_dn;
  logic [DEPTH-1:0]           vld, le, le_up, le_dn, first;
  logic [KW-1:0]              new_key;
  logic                       tup_v, port_ok, do_enq, do_pop, do_drop;
  logic [6:0]                 count_nxt;
  logic [NUM_PORTS-1:0][31:0] last_q;

  assign tup_v   = bus.enq_valid & bus.enq_data[31];
  assign port_ok = bus.enq_data[2:0] < 3'(NUM_PORTS);
  // enq_ready is registered, so a full queue drops even during a same-cycle pop.
  assign do_enq  = tup_v & port_ok & bus.enq_ready;
  assign do_drop = tup_v & ~do_enq;
  assign do_pop  = bus.deq_req & (count != 7'd0);
  assign new_key = key_of(bus.enq_data, cur_epoch);

  // Neighbour views: *_up is slot i+1 (toward tail), *_dn is slot i-1 (toward head).
  assign slot_up = {32'd0, slot_q[DEPTH-1:1]};
  assign slot_dn = {slot_q[DEPTH-2:0], 32'd0};
  assign le_up   = {1'b0, le[DEPTH-1:1]};
  assign le_dn   = {le[DEPTH-2:0], 1'b1};
  assign first   = DEPTH'(1);

  // le[i]: slot i holds an entry that stays ahead of the incoming tuple
  // (key <= new key, so equal keys keep arrival order). le is a run of ones
  // from the head; the insert point is the first zero.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [31:0] nxt;
    assign vld[i] = 7'(i) < count;
    assign le[i]  = vld[i] && (key_of(slot_q[i], cur_epoch) <= new_key);

    always_comb begin
      nxt = slot_q[i];
      if (do_pop && do_enq) begin
        // Head leaves; entries ahead of the insert point move up one, the
        // new tuple lands just behind them, the rest stay put.
        if (le_up[i])                nxt = slot_up[i];
        else if (le[i] || first[i])  nxt = bus.enq_data;
      end else if (do_pop) begin
        nxt = slot_up[i];
      end else if (do_enq) begin
        if (!le[i]) nxt = le_dn[i] ? bus.enq_data : slot_dn[i];
      end
    end
    assign slot_d[i] = nxt;
  end

  assign count_nxt = count + 7'(do_enq) - 7'(do_pop);

  always_ff @(posedge clk_dp or negedge rst_n) begin
    if (!rst_n) begin
      slot_q        <= '0;
      count         <= '0;
      drop_cnt      <= '0;
      cur_epoch     <= '0;
      last_q        <= '0;
      bus.enq_ready <= 1'b0;
      bus.deq_valid <= 1'b0;
      bus.deq_data  <= '0;
    end else begin
      slot_q        <= slot_d;
      count         <= count_nxt;
      bus.enq_ready <= count_nxt < 7'(DEPTH);
      bus.deq_valid <= do_pop;
      if (do_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (do_pop) begin
        bus.deq_data <= slot_q[0];
        cur_epoch    <= slot_q[0][24:23];
        for (int p = 0; p < NUM_PORTS; p++)
          if (slot_q[0][2:0] == 3'(p)) last_q[p] <= slot_q[0];
      end
    end
  end

  assign last_pkt_info0 = last_q[0];
  assign last_pkt_info1 = last_q[1];
  assign last_pkt_info2 = last_q[2];
  assign last_pkt_info3 = last_q[3];
  assign last_pkt_info4 = last_q[4];
endmodule

// File: tb/tb_pifo_rank_queue.sv
// tb_pifo_rank_queue: directed plan scenarios plus randomized traffic, all
// checked against a queue-based reference model (pop = stable min of
// rebased key at pop time).
module tb_pifo_rank_queue;
  logic clk_dp = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_dp = ~clk_dp;

  pifo_rank_queue_if bus();
  logic [31:0] lpi0, lpi1, lpi2, lpi3, lpi4;
  logic [6:0]  count;
  logic [15:0] drop_cnt;
  logic [1:0]  cur_epoch;

  pifo_rank_queue #(.DEPTH(16), .NUM_PORTS(5)) dut (
    .clk_dp(clk_dp), .rst_n(rst_n), .bus(bus),
    .last_pkt_info0(lpi0), .last_pkt_info1(lpi1), .last_pkt_info2(lpi2),
    .last_pkt_info3(lpi3), .last_pkt_info4(lpi4),
    .count(count), .drop_cnt(drop_cnt), .cur_epoch(cur_epoch)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_q[$];
  logic [1:0]  m_ep;
  logic [15:0] m_drop;
  logic [31:0] m_last[5];
  logic        m_dv;
  logic [31:0] m_dd;
  logic        m_rdy;

  function automatic logic [12:0] mkey(input logic [31:0] d);
    return {2'(d[24:23] - m_ep), d[22:12]};
  endfunction

  function automatic int m_head();
    int h = 0;
    for (int i = 1; i < m_q.size(); i++)
      if (mkey(m_q[i]) < mkey(m_q[h])) h = i;
    return h;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_ep = 0; m_drop = 0; m_dv = 0; m_dd = 0; m_rdy = 0;
    for (int p = 0; p < 5; p++) m_last[p] = 0;
  endtask

  task automatic m_step(input logic ev, input logic [31:0] ed, input logic dr);
    logic acc, drp;
    int h;
    logic [1:0] ep_n;
    ep_n = m_ep;
    acc  = ev && ed[31] && (ed[2:0] < 3'd5) && m_rdy;
    drp  = ev && ed[31] && !acc;
    m_dv = 0;
    if (dr && m_q.size() > 0) begin
      h = m_head();
      m_dd = m_q[h];
      m_q.delete(h);
      m_dv = 1;
      m_last[int'(m_dd[2:0])] = m_dd;
      ep_n = m_dd[24:23];
    end
    if (acc) m_q.push_back(ed);
    if (drp && m_drop != 16'hFFFF) m_drop++;
    m_ep  = ep_n;
    m_rdy = m_q.size() < 16;
  endtask

  task automatic check_all(input string tg);
    chk({tg, ".deq_valid"}, 32'(bus.deq_valid), 32'(m_dv));
    chk({tg, ".deq_data"},  bus.deq_data, m_dd);
    chk({tg, ".count"},     32'(count), 32'(m_q.size()));
    chk({tg, ".drop_cnt"},  32'(drop_cnt), 32'(m_drop));
    chk({tg, ".cur_epoch"}, 32'(cur_epoch), 32'(m_ep));
    chk({tg, ".enq_ready"}, 32'(bus.enq_ready), 32'(m_rdy));
    chk({tg, ".lpi0"}, lpi0, m_last[0]);
    chk({tg, ".lpi1"}, lpi1, m_last[1]);
    chk({tg, ".lpi2"}, lpi2, m_last[2]);
    chk({tg, ".lpi3"}, lpi3, m_last[3]);
    chk({tg, ".lpi4"}, lpi4, m_last[4]);
  endtask

  function automatic logic [31:0] mk(input logic [1:0] ovf, input logic [10:0] rnd,
                                     input logic [2:0] port);
    return {1'b1, 1'b0, 5'd0, ovf, rnd, 9'd0, port};
  endfunction

  // One clock: drive, let the edge happen, advance model, compare, release.
  task automatic cyc(input string tg, input logic ev, input logic [31:0] ed, input logic dr);
    bus.enq_valid = ev;
    bus.enq_data  = ed;
    bus.deq_req   = dr;
    @(posedge clk_dp);
    m_step(ev, ed, dr);
    #1;
    check_all(tg);
    bus.enq_valid = 1'b0;
    bus.deq_req   = 1'b0;
  endtask

  // Called 1 ns after an edge; reset pulse sits between edges.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    m_reset();
    #1 check_all("rst");
    #1 rst_n = 1'b1;
    cyc("post_rst", 1'b0, 32'd0, 1'b0);
  endtask

  logic [31:0] d;
  logic        ev, dr;
  logic [1:0]  ovf;

  initial begin
    bus.enq_valid = 1'b0;
    bus.enq_data  = '0;
    bus.deq_req   = 1'b0;
    m_reset();
    #1 check_all("init");
    @(posedge clk_dp);
    #1 check_all("init_edge");
    #2 rst_n = 1'b1;
    cyc("idle", 1'b0, 32'd0, 1'b0);

    // 1. Sort
    cyc("t1", 1'b1, mk(0, 5, 0), 1'b0);
    cyc("t1", 1'b1, mk(0, 2, 0), 1'b0);
    cyc("t1", 1'b1, mk(0, 9, 0), 1'b0);
    chk("t1.count3", 32'(count), 32'd3);
    cyc("t1", 1'b0, 32'd0, 1'b1);
    chk("t1.pop_r2", 32'(bus.deq_data[22:12]), 32'd2);
    cyc("t1", 1'b0, 32'd0, 1'b1);
    chk("t1.pop_r5", 32'(bus.deq_data[22:12]), 32'd5);
    cyc("t1", 1'b0, 32'd0, 1'b1);
    chk("t1.pop_r9", 32'(bus.deq_data[22:12]), 32'd9);
    chk("t1.lpi0", lpi0, mk(0, 9, 0));
    chk("t1.count0", 32'(count), 32'd0);
    cyc("t1_empty", 1'b0, 32'd0, 1'b1);
    chk("t1.empty_pop", 32'(bus.deq_valid), 32'd0);

    // 2. Ties
    cyc("t2", 1'b1, mk(0, 3, 1), 1'b0);
    cyc("t2", 1'b1, mk(0, 3, 2), 1'b0);
    cyc("t2", 1'b0, 32'd0, 1'b1);
    chk("t2.first_port1", 32'(bus.deq_data[2:0]), 32'd1);
    cyc("t2", 1'b0, 32'd0, 1'b1);
    chk("t2.second_port2", 32'(bus.deq_data[2:0]), 32'd2);
    chk("t2.lpi1", lpi1, mk(0, 3, 1));
    chk("t2.lpi2", lpi2, mk(0, 3, 2));
    chk("t2.lpi0_kept", lpi0, mk(0, 9, 0));

    // 3. Full, then bad port
    do_reset();
    for (int i = 0; i < 16; i++)
      cyc("t3", 1'b1, mk(0, 11'($urandom_range(0, 50)), 0), 1'b0);
    chk("t3.ready_low", 32'(bus.enq_ready), 32'd0);
    cyc("t3", 1'b1, mk(0, 1, 0), 1'b0);
    chk("t3.drop1", 32'(drop_cnt), 32'd1);
    chk("t3.count16", 32'(count), 32'd16);
    do_reset();
    cyc("t3b", 1'b1, mk(0, 1, 6), 1'b0);
    chk("t3b.drop1", 32'(drop_cnt), 32'd1);
    chk("t3b.count0", 32'(count), 32'd0);

    // 4. Epoch wrap
    do_reset();
    cyc("t4", 1'b1, mk(3, 0, 0), 1'b0);
    cyc("t4", 1'b0, 32'd0, 1'b1);
    chk("t4.epoch3", 32'(cur_epoch), 32'd3);
    cyc("t4", 1'b1, mk(0, 1, 0), 1'b0);
    cyc("t4", 1'b1, mk(3, 2000, 0), 1'b0);
    cyc("t4", 1'b0, 32'd0, 1'b1);
    chk("t4.first", bus.deq_data, mk(3, 2000, 0));
    cyc("t4", 1'b0, 32'd0, 1'b1);
    chk("t4.second", bus.deq_data, mk(0, 1, 0));
    chk("t4.epoch0", 32'(cur_epoch), 32'd0);

    // 5. Simultaneous enqueue + pop
    do_reset();
    cyc("t5", 1'b1, mk(0, 40, 0), 1'b0);
    cyc("t5", 1'b1, mk(0, 20, 1), 1'b0);
    cyc("t5", 1'b1, mk(0, 30, 2), 1'b0);
    cyc("t5", 1'b1, mk(0, 10, 3), 1'b0);
    cyc("t5", 1'b1, mk(0, 5, 4), 1'b1);
    chk("t5.popped10", 32'(bus.deq_data[22:12]), 32'd10);
    chk("t5.count4", 32'(count), 32'd4);
    cyc("t5", 1'b0, 32'd0, 1'b1);
    chk("t5.head5", 32'(bus.deq_data[22:12]), 32'd5);

    // 6. Reset mid-operation
    do_reset();
    for (int i = 0; i < 10; i++)
      cyc("t6", 1'b1, mk(0, 11'($urandom_range(0, 20)), 3'(i % 5)), 1'b0);
    cyc("t6", 1'b0, 32'd0, 1'b1);
    cyc("t6", 1'b0, 32'd0, 1'b1);
    chk("t6.count8", 32'(count), 32'd8);
    bus.deq_req = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("t6.count_async", 32'(count), 32'd0);
    chk("t6.dv_async", 32'(bus.deq_valid), 32'd0);
    chk("t6.lpi_async", lpi0 | lpi1 | lpi2 | lpi3 | lpi4, 32'd0);
    m_reset();
    check_all("t6_rst");
    rst_n = 1'b1;
    @(posedge clk_dp);
    m_step(1'b0, 32'd0, 1'b1);
    #1 check_all("t6_after");
    chk("t6.pop_after", 32'(bus.deq_valid), 32'd0);
    bus.deq_req = 1'b0;

    // Random traffic: alternating fill-heavy and drain-heavy phases.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      ev = $urandom_range(0, 99) < (((n / 100) % 2) != 0 ? 30 : 80);
      dr = $urandom_range(0, 99) < (((n / 100) % 2) != 0 ? 80 : 30);
      // Keep entries within one epoch ahead; a same-cycle insert shares the
      // popped head's epoch so rebasing cannot wrap it.
      if (dr && m_q.size() > 0) ovf = m_q[m_head()][24:23];
      else                      ovf = m_ep + 2'($urandom_range(0, 1));
      d = {1'($urandom_range(0, 9) != 0), 1'($urandom), 5'($urandom), ovf,
           11'($urandom_range(0, 7)), 9'($urandom), 3'($urandom_range(0, 6))};
      cyc("rnd", ev, d, dr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pifo_rank_queue.md
Name: pifo_rank_queue

Overview:
- Sorted rank queue directly downstream of the WRR rank calculator (wrr_without_blkmem).
- Consumes its 32-bit rank tuple and holds up to DEPTH packet descriptors ordered by WRR rank; the smallest rank leaves first.
- Per port, drives the last dequeued rank back to the rank calculator's wire_in_last_pkt_info0..4 inputs, closing the outage/catch-up loop.

Parameters:
DEPTH, 16, number of queue slots (2..64)
NUM_PORTS, 5, number of last_pkt_info outputs (fixed at 5 for this build)

Ports:
clk_dp  in  1  data-plane clock
rst_n  in  1  asynchronous, active-low reset
enq_valid  in  1  rank tuple valid (from tuple_out_my_pifo_rank_calc_output_VALID)
enq_data  in  32  {v[31], rank[30:12], reserved[11:0]}; rank = {unused, class[4:0], ovf[1:0], round[10:0]}; reserved[2:0] = port index
enq_ready  out  1  high when count < DEPTH
deq_req  in  1  scheduler pop request
deq_valid  out  1  one-cycle pulse: deq_data holds the popped entry
deq_data  out  32  popped tuple, unmodified
last_pkt_info0..4  out  32 each  last tuple dequeued for port 0..4
count  out  7  current occupancy
drop_cnt  out  16  saturating count of rejected enqueues
cur_epoch  out  2  ovf field of the most recent dequeue

Behaviour:
- Reset: one clock clk_dp; rst_n is asynchronous and active-low. While rst_n=0, all outputs, all slots, count, drop_cnt and cur_epoch are 0.
- Accept condition: an enqueue is accepted when enq_valid=1, enq_data[31]=1, reserved[2:0]<5 and enq_ready=1.
- Rejected enqueue: valid but v=0 is ignored silently. A port index >4, or arriving when full, is dropped and drop_cnt increments (saturates at 0xFFFF).
- Sort key: 13-bit {(ovf - cur_epoch) mod 4, round}. It is computed every cycle from the stored fields, so a change of cur_epoch re-bases all keys. Class and the unused bit do not participate.
- Ordering: ascending key, slot 0 = head. Equal keys keep arrival order: a new entry goes after every existing entry with an equal key.
- Structure: shift-register PIFO. Each slot compares its key against the incoming key in parallel. Insert takes 1 cycle, so the entry is visible at the head the cycle after acceptance.
- Dequeue: deq_req=1 with count>0 pops slot 0. On the next edge:
  - deq_valid=1 and deq_data=old head;
  - last_pkt_info[port]=old head;
  - cur_epoch=old head ovf;
  - the remaining slots shift toward the head.
- Empty pop: deq_req with count=0 gives deq_valid=0 and no state change.
- deq_valid is a single-cycle pulse. deq_data holds its value until the next pop.
- Simultaneous enqueue and dequeue in one cycle: both are performed and count is unchanged.
  - enq_ready stays registered (count<DEPTH), so when full an arriving enqueue is dropped even if a pop happens in the same cycle.
  - If the new key is smaller than all stored keys, the popped entry is the old head and the new entry becomes the head.
- Epoch coverage: the key assumes stored entries span at most 3 epochs ahead of cur_epoch. Beyond that, ordering is undefined; this case is not checked.
- last_pkt_info for a port with no dequeue since reset stays 0.
- Reset asserted mid-operation: all contents are lost immediately, and outputs go to 0 asynchronously.

Test Plan:
1. Sort
   - Stimulus (DEPTH=16): enqueue port 0 tuples with ovf=0, rounds 5, 2, 9; then 3 pops.
   - Required: deq_data rounds 2, 5, 9; last_pkt_info0 = round-9 tuple; count 3→0.
2. Ties
   - Stimulus: enqueue round 3 on port 1, then round 3 on port 2, then pop twice.
   - Required: port 1 entry first, then port 2. last_pkt_info1 and last_pkt_info2 are each updated; last_pkt_info0 is unchanged.
3. Full
   - Stimulus: 17 enqueues on port 0.
   - Required: enq_ready=0 after the 16th accept; drop_cnt=1; count=16. Same result for one enqueue with reserved[2:0]=6 (drop_cnt=1).
4. Epoch wrap
   - Stimulus: pop an ovf=3 entry so cur_epoch=3; enqueue ovf=0 round 1, then ovf=3 round 2000.
   - Required: ovf=3/2000 dequeued first, then ovf=0/1; cur_epoch ends at 0.
5. Simultaneous
   - Stimulus: with 4 entries (rounds 10, 20, 30, 40), in one cycle enqueue round 5 and assert deq_req.
   - Required: popped round 10; new head round 5; count stays 4.
6. Reset mid-operation
   - Stimulus: with 8 entries and a pending deq_req, drop rst_n for 1 ns off-edge.
   - Required: count=0, deq_valid=0, all last_pkt_info=0 immediately. The next pop after release gives deq_valid=0.
